// File: rtl/mux_sweep_checker_if.sv
// Signal bundle between the mux sweep checker and the mux under test / its controller.
// slave  : the checker (receives start/probe, drives stimulus and status).
// master : the controlling side (drives start/probe, observes stimulus and status).
interface mux_sweep_checker_if;
  logic       start;
  logic       S;
  logic       I0;
  logic       I1;
  logic [8:0] probe;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] fail_vec;

  modport slave (
    input  start, probe,
    output S, I0, I1, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport master (
    output start, probe,
    input  S, I0, I1, busy, done, pass, err_count, fail_valid, fail_vec
  );
endinterface

// File: rtl/mux_sweep_checker.sv
// Exhaustive 2:1 mux sweep checker: drives all eight {S,I1,I0} vectors, waits one settle
// cycle per vector, compares the mux probe and records the failure count and first failure.
// Optional macro PROBE_FULL_CHECK_EN: also checks the I0/I1/S/~S probe echo bits.
module mux_sweep_checker (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_sweep_checker_if.slave   bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_vec;
  logic       r_s;
  logic       r_i0;
  logic       r_i1;
  logic [3:0] r_err_count;
  logic       r_fail_valid;
  logic [2:0] r_fail_vec;

  logic       w_accept;
  logic       w_expected;
  logic       w_mismatch;
  logic       w_unused_probe;

  assign w_accept   = ((r_state == StIdle) || (r_state == StDone)) && bus.start;
  assign w_expected = r_s ? r_i1 : r_i0;

  // Per-vector failure: mux output always; echo bits only in the full-check build.
`ifdef PROBE_FULL_CHECK_EN
  assign w_mismatch = (bus.probe[8] != w_expected) ||
                      (bus.probe[0] != r_i0)       ||
                      (bus.probe[1] != r_i1)       ||
                      (bus.probe[2] != r_s)        ||
                      (bus.probe[5] != ~r_s);
`else
  assign w_mismatch = (bus.probe[8] != w_expected);
`endif

  // Probe bits that are never compared in some builds.
  assign w_unused_probe = ^bus.probe[7:0];

  // State register; reset aborts any sweep immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: three cycles per vector, start only honoured when not busy.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle,
      StDone:   if (bus.start) w_state_next = StDrive;
      StDrive:  w_state_next = StSettle;
      StSettle: w_state_next = StCheck;
      StCheck:  w_state_next = (r_vec == 3'd7) ? StDone : StDrive;
      default:  w_state_next = StIdle;
    endcase
  end

  // Sweep datapath: stimulus load, vector index, error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= 3'd0;
      r_s          <= 1'b0;
      r_i0         <= 1'b0;
      r_i1         <= 1'b0;
      r_err_count  <= 4'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
    end else if (w_accept) begin
      // Stimulus is left as-is; it only returns to 0 on reset.
      r_vec        <= 3'd0;
      r_err_count  <= 4'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
    end else if (r_state == StDrive) begin
      {r_s, r_i1, r_i0} <= r_vec;
    end else if (r_state == StCheck) begin
      if (w_mismatch) begin
        if (r_err_count != 4'hF) r_err_count <= r_err_count + 4'd1;
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_vec   <= r_vec;
        end
      end
      if (r_vec != 3'd7) r_vec <= r_vec + 3'd1;
    end
  end

  assign bus.S          = r_s;
  assign bus.I0         = r_i0;
  assign bus.I1         = r_i1;
  assign bus.busy       = (r_state == StDrive) || (r_state == StSettle) || (r_state == StCheck);
  assign bus.done       = (r_state == StDone);
  assign bus.pass       = (r_state == StDone) && (r_err_count == 4'd0);
  assign bus.err_count  = r_err_count;
  assign bus.fail_valid = r_fail_valid;
  assign bus.fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Directed bench for mux_sweep_checker with a selectable behavioural mux model on the probe.
module tb_mux_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;

  mux_sweep_checker_if bus ();

  mux_sweep_checker dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Mux model: 0 ideal, 1 I1|(I0&~S), 2 output stuck 0, 3 ideal with probe[5] stuck 0.
  always_comb begin
    bus.probe    = '0;
    bus.probe[0] = bus.I0;
    bus.probe[1] = bus.I1;
    bus.probe[2] = bus.S;
    bus.probe[5] = ~bus.S;
    case (mode)
      1:       bus.probe[8] = bus.I1 | (bus.I0 & ~bus.S);
      2:       bus.probe[8] = 1'b0;
      3: begin
        bus.probe[8] = bus.S ? bus.I1 : bus.I0;
        bus.probe[5] = 1'b0;
      end
      default: bus.probe[8] = bus.S ? bus.I1 : bus.I0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Accepting edge is consumed here; returns #1 after it.
  task automatic launch(input int m, input bit hold);
    @(negedge clk);
    mode      = m;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = hold;
  endtask

  // Counts edges until done is seen; optionally pokes start for one cycle at poke_at.
  task automatic wait_done(input int poke_at, input bit hold, output int cycles);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      cycles++;
      #1;
      if (bus.done) break;
      bus.start = hold || (cycles == poke_at);
    end
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cycles, input int exp_err,
                              input int exp_fv, input int exp_fvec);
    check({tag, ".cycles"},     cycles,         24);
    check({tag, ".done"},       bus.done,       1);
    check({tag, ".busy"},       bus.busy,       0);
    check({tag, ".pass"},       bus.pass,       (exp_err == 0) ? 1 : 0);
    check({tag, ".err_count"},  bus.err_count,  exp_err);
    check({tag, ".fail_valid"}, bus.fail_valid, exp_fv);
    check({tag, ".fail_vec"},   bus.fail_vec,   exp_fvec);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},       bus.busy,       0);
    check({tag, ".done"},       bus.done,       0);
    check({tag, ".pass"},       bus.pass,       0);
    check({tag, ".err_count"},  bus.err_count,  0);
    check({tag, ".fail_valid"}, bus.fail_valid, 0);
    check({tag, ".fail_vec"},   bus.fail_vec,   0);
    check({tag, ".stim"},       {bus.S, bus.I1, bus.I0}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    mode      = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ideal mux: clean pass, stimulus parks at the last vector.
    launch(0, 1'b0);
    wait_done(0, 1'b0, cyc);
    check_result("ideal", cyc, 0, 0, 0);
    check("ideal.stim_last", {bus.S, bus.I1, bus.I0}, 3'b111);
    repeat (3) @(negedge clk);
    check("ideal.done_held", bus.done, 1);
    check("ideal.stim_held", {bus.S, bus.I1, bus.I0}, 3'b111);

    // Faulty model fails only vector 010.
    launch(1, 1'b0);
    wait_done(0, 1'b0, cyc);
    check_result("or_model", cyc, 1, 1, 3'b010);

    // Output stuck at 0 fails 001, 011, 110, 111.
    launch(2, 1'b0);
    wait_done(0, 1'b0, cyc);
    check_result("stuck0", cyc, 4, 1, 3'b001);

    // Asynchronous reset at cycle 10 of a failing sweep wipes everything.
    launch(2, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    check("abort.err_before", bus.err_count, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    check("abort.idle", bus.busy, 0);
    rst_n     = 1'b1;
    mode      = 0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort.first_accept", bus.busy, 1);
    wait_done(0, 1'b0, cyc);
    check_result("after_abort", cyc, 0, 0, 0);

    // start pulse while busy is ignored.
    launch(0, 1'b0);
    wait_done(5, 1'b0, cyc);
    check_result("mid_start", cyc, 0, 0, 0);

    // start held high: back-to-back sweeps, one-cycle done pulse.
    launch(0, 1'b1);
    wait_done(0, 1'b1, cyc);
    check_result("held1", cyc, 0, 0, 0);
    @(posedge clk);
    #1;
    check("held.done_pulse", bus.done, 0);
    check("held.restart_busy", bus.busy, 1);
    wait_done(0, 1'b1, cyc);
    check_result("held2", cyc, 0, 0, 0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("held.done_stays", bus.done, 1);

    // probe[5] stuck at 0: only seen by the full-check build.
    launch(3, 1'b0);
    wait_done(0, 1'b0, cyc);
`ifdef PROBE_FULL_CHECK_EN
    check_result("not_s_stuck", cyc, 4, 1, 3'b000);
`else
    check_result("not_s_stuck", cyc, 0, 0, 3'b000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sweep_checker.md
MUX_SWEEP_CHECKER -- requirements
Module: mux_sweep_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  run request; sampled only in IDLE or DONE.
REQ-005 S  output  1  registered select stimulus to the downstream 2:1 mux under test.
REQ-006 I0  output  1  registered data-0 stimulus.
REQ-007 I1  output  1  registered data-1 stimulus.
REQ-008 probe  input  9  mux probe vector. [0]=I0 echo, [1]=I1 echo, [2]=S echo, [5]=~S, [8]=mux output.
REQ-009 busy  output  1  high while a sweep is running.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 pass  output  1  high when done=1 and err_count=0.
REQ-012 err_count  output  4  number of failing vectors in the current or last sweep (range 0..8).
REQ-013 fail_valid  output  1  high once any vector has failed in the current or last sweep.
REQ-014 fail_vec  output  3  {S,I1,I0} of the first failing vector; held until the next accepted start.

Function
REQ-015 States SHALL be IDLE, DRIVE, SETTLE, CHECK and DONE; vector index vec is 3 bits.
REQ-016 In IDLE or DONE with start=1, the block SHALL go to DRIVE and clear vec, err_count, fail_valid, fail_vec, done and pass.
REQ-017 DRIVE SHALL load {S,I1,I0} <= vec and go to SETTLE.
REQ-018 SETTLE SHALL hold the stimulus for one cycle and go to CHECK.
REQ-019 CHECK SHALL compare probe[8] with expected (S ? I1 : I0), using the registered stimulus.
REQ-020 On a mismatch, CHECK SHALL increment err_count. On the first mismatch of a sweep, it SHALL also set fail_valid and capture fail_vec=vec.
REQ-021 From CHECK with vec<7, the block SHALL increment vec and go to DRIVE. With vec=7, it SHALL go to DONE.
REQ-022 Each vector SHALL take 3 cycles. done SHALL rise exactly 24 cycles after the edge that accepted start.
REQ-023 busy SHALL be high in DRIVE, SETTLE and CHECK only.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 start held high continuously SHALL restart a sweep on the cycle after DONE is entered. done SHALL pulse for one cycle in that case.
REQ-026 Stimulus outputs SHALL hold their last value in DONE. They SHALL return to 0 only on reset.
REQ-027 err_count SHALL NOT wrap; 8 is the maximum reachable value.

Reset
REQ-028 On rst_n=0, the block SHALL enter IDLE immediately, independent of clk.
REQ-029 Reset SHALL clear S, I0, I1, busy, done, pass, err_count, fail_valid, fail_vec and vec.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; no partial result SHALL remain.
REQ-031 The first start after reset release SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Configuration
REQ-032 Macro PROBE_FULL_CHECK_EN: when defined, CHECK SHALL additionally require probe[0]=I0, probe[1]=I1, probe[2]=S and probe[5]=~S.
REQ-033 Under PROBE_FULL_CHECK_EN, any bit mismatch in a vector SHALL count as one failing vector.
REQ-034 When PROBE_FULL_CHECK_EN is undefined, only probe[8] SHALL be checked and the other probe bits SHALL be ignored.

Verification
REQ-035 Scenario 1: ideal mux model, start pulse -> done after 24 cycles; pass=1, err_count=0, fail_valid=0.
REQ-036 Scenario 2: model with probe[8]=I1|(I0&~S) -> one failing vector; err_count=1, fail_vec=3'b010, pass=0.
REQ-037 Scenario 3: probe[8] stuck at 0 -> err_count=4, fail_vec=3'b001.
REQ-038 Scenario 4: rst_n low at cycle 10 of a sweep -> all outputs 0 and IDLE. A new start then gives a full 24-cycle sweep.
REQ-039 Scenario 5: start pulsed mid-sweep -> no restart, and done still arrives at cycle 24. start held high -> back-to-back sweeps with a 1-cycle done pulse.
REQ-040 Scenario 6: with PROBE_FULL_CHECK_EN defined, probe[5] forced to 0 -> err_count=4, fail_vec=3'b000. Without the macro, the same model gives pass=1.
